// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports and the data-memory
// port of dmem_arbiter.
//
// Handshake: a requester raises pN_req with we/size/uns/addr/wdata and holds
// them unchanged until it sees pN_ack. pN_ack is a one-cycle pulse, and
// pN_err is valid in that same cycle. On the edge after ack, the requester
// either drops req or presents the next request. pN_rdata holds the last
// successful load result until the next ack on that port.
//
// Memory side: mem_rdata is the combinational read of the word at mem_addr.
// The word at mem_addr is written with mem_wdata at the clock edge while
// mem_we is high.
//
// dbg_state exposes the arbiter FSM state for observation.
//
// Modports:
//   slave  - the arbiter
//   master - requesters plus the memory model (the environment)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [1:0]        p0_size;
  logic              p0_uns;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata;
  logic              p0_ack;
  logic              p0_err;
  logic [31:0]       p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [1:0]        p1_size;
  logic              p1_uns;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata;
  logic              p1_ack;
  logic              p1_err;
  logic [31:0]       p1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [1:0]        dbg_state;

  modport slave (
    input  p0_req, p0_we, p0_size, p0_uns, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_size, p1_uns, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_we, mem_addr, mem_wdata,
    output dbg_state
  );

  modport master (
    output p0_req, p0_we, p0_size, p0_uns, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_size, p1_uns, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    input  dbg_state
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of a byte-addressed,
// little-endian data memory. The memory has a combinational word read, a
// synchronous word write, and no byte enables.
//
// Port 0 is the core load/store unit. Port 1 is the debug/loader master.
// The arbiter checks alignment and range, extracts bytes and halves with
// sign or zero extension, and performs read-modify-write for sub-word stores.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - dmem_arbiter_if.slave (requester ports, memory port, dbg_state)
//
// Build option: DMEM_ARB_FIXED_PRIO_EN
//   Defined:   port 0 always wins simultaneous requests, so port 1 can starve.
//   Undefined: round-robin between the two ports.
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACCESS   = 2'd1;
  localparam logic [1:0] S_MERGE_WR = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

  logic [1:0]        state;
  logic              t_port;
  logic              t_we;
  logic              t_uns;
  logic [1:0]        t_size;
  logic [ADDR_W-1:0] t_addr;
  logic [31:0]       t_wdata;
  logic [31:0]       merged;
  logic              ack0, ack1, err0, err1;
  logic [31:0]       rdata0, rdata1;

  // Grant selection, evaluated in IDLE.
  logic grant1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign grant1 = bus.p1_req & ~bus.p0_req;
`else
  // prio names the port that wins a tie. It is always the port that was
  // not granted last, and it resets to 0 so port 0 is favoured first.
  logic prio;
  assign grant1 = bus.p1_req & (~bus.p0_req | prio);
`endif

  logic              any_req;
  logic              g_we, g_uns, g_err;
  logic [1:0]        g_size;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_wdata;

  assign any_req = bus.p0_req | bus.p1_req;
  assign g_we    = grant1 ? bus.p1_we    : bus.p0_we;
  assign g_uns   = grant1 ? bus.p1_uns   : bus.p0_uns;
  assign g_size  = grant1 ? bus.p1_size  : bus.p0_size;
  assign g_addr  = grant1 ? bus.p1_addr  : bus.p0_addr;
  assign g_wdata = grant1 ? bus.p1_wdata : bus.p0_wdata;

  // A rejected request never reaches the memory.
  assign g_err = (g_size == 2'b11)
               | ((g_size == 2'b01) & g_addr[0])
               | ((g_size == 2'b10) & (g_addr[1:0] != 2'b00))
               | (g_addr > LAST_ADDR);

  logic [ADDR_W-1:0] word_addr;
  logic              word_store;

  assign word_addr  = {t_addr[ADDR_W-1:2], 2'b00};
  assign word_store = t_we & (t_size == 2'b10);

  // Lane extraction for loads and lane insertion for sub-word stores.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  always_comb begin
    ld_byte   = bus.mem_rdata[{t_addr[1:0], 3'b000} +: 8];
    ld_half   = bus.mem_rdata[{t_addr[1], 4'b0000} +: 16];
    load_val  = bus.mem_rdata;
    merge_val = bus.mem_rdata;
    case (t_size)
      2'b00: begin
        load_val = {{24{ld_byte[7] & ~t_uns}}, ld_byte};
        merge_val[{t_addr[1:0], 3'b000} +: 8] = t_wdata[7:0];
      end
      2'b01: begin
        load_val = {{16{ld_half[15] & ~t_uns}}, ld_half};
        merge_val[{t_addr[1], 4'b0000} +: 16] = t_wdata[15:0];
      end
      default: ;
    endcase
  end

  // The memory bus is driven only in ACCESS and MERGE_WR; it is 0 otherwise.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      S_ACCESS: begin
        bus.mem_addr = word_addr;
        if (word_store) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = t_wdata;
        end
      end
      S_MERGE_WR: begin
        bus.mem_addr  = word_addr;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merged;
      end
      default: ;
    endcase
  end

  // ack/err are registered on entry to RESP, so they are high for exactly
  // the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      t_port  <= 1'b0;
      t_we    <= 1'b0;
      t_uns   <= 1'b0;
      t_size  <= 2'b00;
      t_addr  <= '0;
      t_wdata <= '0;
      merged  <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      prio    <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            t_port  <= grant1;
            t_we    <= g_we;
            t_uns   <= g_uns;
            t_size  <= g_size;
            t_addr  <= g_addr;
            t_wdata <= g_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            prio    <= ~grant1;
`endif
            if (g_err) begin
              {ack1, ack0} <= grant1 ? 2'b10 : 2'b01;
              {err1, err0} <= grant1 ? 2'b10 : 2'b01;
              state        <= S_RESP;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!t_we) begin
            if (t_port) rdata1 <= load_val;
            else        rdata0 <= load_val;
            {ack1, ack0} <= t_port ? 2'b10 : 2'b01;
            state        <= S_RESP;
          end else if (word_store) begin
            {ack1, ack0} <= t_port ? 2'b10 : 2'b01;
            state        <= S_RESP;
          end else begin
            merged <= merge_val;
            state  <= S_MERGE_WR;
          end
        end
        S_MERGE_WR: begin
          {ack1, ack0} <= t_port ? 2'b10 : 2'b01;
          state        <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.p0_ack    = ack0;
  assign bus.p1_ack    = ack1;
  assign bus.p0_err    = err0;
  assign bus.p1_err    = err1;
  assign bus.p0_rdata  = rdata0;
  assign bus.p1_rdata  = rdata1;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bench for dmem_arbiter.
//
// The bench drives both requester ports and provides a word memory. Results
// are compared against a byte-array reference model of the memory and the
// arbitration rule.
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- memory behind the arbiter ----------------
  logic [31:0] mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (poke_en)          mem[poke_idx] <= poke_val;
    else if (bus.mem_we)  mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_b [MEM_BYTES];
  logic [31:0] exp_rdata [2];
  int          model_last;
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    if (size == 2'b01 && addr[0]) return 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
    if (addr > 32'(MEM_BYTES - 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_b[a + 3], ref_b[a + 2], ref_b[a + 1], ref_b[a]};
  endfunction

  task automatic model_apply(input int p, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic [31:0] v, m;
    n = 1 << size;
    if (model_err(size, addr)) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_b[addr + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_b[addr + i]) << (8 * i));
      if (!uns && n < 4) begin
        m = (32'h1 << (8 * n)) - 32'h1;
        if (v[8*n-1]) v = v | ~m;
      end
      exp_rdata[p] = v;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = a[9:2];
    poke_val = v;
    for (int i = 0; i < 4; i++) ref_b[{a[31:2], 2'b00} + i] = v[8*i +: 8];
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic set_req(input int p, input logic req, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_size = size;
      bus.p0_uns = uns; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_size = size;
      bus.p1_uns = uns; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? bus.p0_ack : bus.p1_ack;
  endfunction

  function automatic logic get_err(input int p);
    return (p == 0) ? bus.p0_err : bus.p1_err;
  endfunction

  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? bus.p0_rdata : bus.p1_rdata;
  endfunction

  // One transaction on one port. Latency is counted in rising edges from
  // the sampling edge (edge 1) up to the ack cycle.
  task automatic run_txn(input int p, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic e, seen;
    int lat, n, we_cnt, we_pos;
    e   = model_err(size, addr);
    lat = e ? 1 : ((we && size != 2'b10) ? 3 : 2);
    @(negedge clk);
    set_req(p, 1'b1, we, size, uns, addr, wdata);
    n = 0; seen = 1'b0; we_cnt = 0; we_pos = 0;
    while (!seen && n < 12) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.mem_we) begin
        we_cnt++;
        we_pos = n;
      end
      if (get_ack(p)) seen = 1'b1;
    end
    set_req(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    model_apply(p, we, size, uns, addr, wdata);
    model_last = p;
    check("ack_latency", 32'(n), 32'(lat));
    check("err", 32'(get_err(p)), 32'(e));
    check("rdata", get_rdata(p), exp_rdata[p]);
    check("mem_we_cycles", 32'(we_cnt), (we && !e) ? 32'd1 : 32'd0);
    if (we && !e) begin
      check("mem_we_pos", 32'(we_pos), 32'(lat - 1));
      check("mem_word", mem[addr[9:2]], ref_word({addr[31:2], 2'b00}));
    end
  endtask

  // Both ports issue n_each back-to-back word loads. The expected grant
  // order comes from the arbitration rule applied to the pending counts.
  task automatic run_pair(input int n_each);
    int rem_model [2];
    int rem_issue [2];
    logic [31:0] cur_addr [2];
    int last, acks, g;
    logic [31:0] ev, ep;
    exp_q.delete();
    rem_model[0] = n_each;
    rem_model[1] = n_each;
    last = model_last;
    for (int k = 0; k < 2 * n_each; k++) begin
      if (rem_model[0] > 0 && rem_model[1] > 0) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = (last == 0) ? 1 : 0;
`endif
      end else begin
        g = (rem_model[0] > 0) ? 0 : 1;
      end
      exp_q.push_back(32'(g));
      rem_model[g]--;
      last = g;
    end
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      cur_addr[p]  = 32'($urandom_range(0, 255)) << 2;
      rem_issue[p] = n_each - 1;
      set_req(p, 1'b1, 1'b0, 2'b10, 1'b0, cur_addr[p], 32'h0);
    end
    acks = 0;
    for (int c = 0; c < 20 * n_each && acks < 2 * n_each; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (get_ack(p)) begin
          acks++;
          ep = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          check("grant_order", 32'(p), ep);
          ev = ref_word(cur_addr[p]);
          exp_rdata[p] = ev;
          model_last = p;
          check("pair_rdata", get_rdata(p), ev);
          check("pair_err", 32'(get_err(p)), 32'd0);
          if (rem_issue[p] > 0) begin
            rem_issue[p]--;
            cur_addr[p] = 32'($urandom_range(0, 255)) << 2;
            set_req(p, 1'b1, 1'b0, 2'b10, 1'b0, cur_addr[p], 32'h0);
          end else begin
            set_req(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
          end
        end
      end
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("pair_acks", 32'(acks), 32'(2 * n_each));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] orig, a, r;
    logic [1:0]  sz;
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    model_last = 1;
    rst = 1'b0;

    for (int w = 0; w < 256; w++) poke(32'(w) << 2, $urandom);

    @(negedge clk);
    check("reset_ack_err", {28'h0, bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 32'h0);
    check("reset_mem_we", 32'(bus.mem_we), 32'h0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    check("reset_rdata0", bus.p0_rdata, 32'h0);
    check("reset_rdata1", bus.p1_rdata, 32'h0);
    rst = 1'b1;

    // Directed cases from the test plan.
    poke(32'h0C, 32'h80FF1234);
    run_txn(0, 1'b0, 2'b00, 1'b0, 32'h0F, 32'h0);
    check("lb_signed", bus.p0_rdata, 32'hFFFFFF80);
    run_txn(0, 1'b0, 2'b00, 1'b1, 32'h0F, 32'h0);
    check("lb_unsigned", bus.p0_rdata, 32'h00000080);
    run_txn(0, 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF);
    check("sh_merge", mem[3], 32'hBEEF1234);
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0);
    run_txn(1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678);
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    run_txn(0, 1'b0, 2'b00, 1'b1, 32'h3FD, 32'h0);
    run_txn(0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0);
    run_txn(1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);

    // Contention.
    run_pair(2);

    // Random single-port traffic, concentrated in a small window so that
    // sub-word stores and loads keep hitting the same words.
    for (int k = 0; k < 60; k++) begin
      r  = 32'($urandom_range(0, 9));
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1016, 1040))
                                       : 32'($urandom_range(0, 63));
      run_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), sz,
              1'($urandom_range(0, 1)), a, $urandom);
    end

    run_pair(3);

    // Reset during MERGE_WR of a byte store: memory must stay unchanged.
    orig = ref_word(32'h10);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h000000AA);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_ack_err", {28'h0, bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_rdata0", bus.p0_rdata, 32'h0);
    check("rst_rdata1", bus.p1_rdata, 32'h0);
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_kept", mem[4], orig);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    model_last = 1;
    rst = 1'b1;
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("rst_reload", bus.p0_rdata, orig);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
